// File: rtl/router_oport_arb_if.sv
// router_oport_arb_if: requester-side inputs and forwarded outputs of one router output port
interface router_oport_arb_if;
  logic [15:0] req;
  logic [15:0] din;
  logic [15:0] frame_n;
  logic [15:0] valid_n;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy_n;
  logic        dout;
  logic        frameo_n;
  logic        valido_n;
  logic        timeout;
  modport master (
    output req, din, frame_n, valid_n,
    input  grant, grant_id, busy_n, dout, frameo_n, valido_n, timeout
  );
  modport slave (
    input  req, din, frame_n, valid_n,
    output grant, grant_id, busy_n, dout, frameo_n, valido_n, timeout
  );
endinterface

// File: rtl/router_oport_arb.sv
// router_oport_arb: 16-way round-robin output-port arbiter with serial forwarding; ROUTER_OPORT_ARB_TIMEOUT_EN enables idle-data forced release
module router_oport_arb #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               clock,
  input logic               reset_n,
  router_oport_arb_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, RELEASE = 2'd2;
  logic [1:0] state;
  logic [3:0] last_ptr, pick;
  logic       started, fin, to_hit;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end
  // rotating priority: the lowest offset above last_ptr wins, so scan offsets from high to low
  always_comb begin
    pick = '0;
    for (int k = 16; k >= 1; k--)
      if (bus.req[last_ptr + 4'(k)]) pick = last_ptr + 4'(k);
  end
  assign fin = state == XFER && started && bus.frame_n[bus.grant_id];
`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  assign to_hit = state == XFER && bus.valid_n[bus.grant_id] && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
  // consecutive owner cycles without valid data; zero outside XFER so every grant starts fresh
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) idle_cnt <= '0;
    else idle_cnt <= (state == XFER && bus.valid_n[bus.grant_id]) ? idle_cnt + 16'd1 : '0;
`else
  assign to_hit = 1'b0;
`endif
  // arbitration, one-cycle forwarding and the single release cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      last_ptr     <= 4'd15;
      started      <= 1'b0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.busy_n   <= 1'b1;
      bus.dout     <= 1'b0;
      bus.frameo_n <= 1'b1;
      bus.valido_n <= 1'b1;
      bus.timeout  <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: if (|bus.req) begin
          state        <= XFER;
          started      <= 1'b0;
          bus.grant    <= 16'd1 << pick;
          bus.grant_id <= pick;
          bus.busy_n   <= 1'b0;
        end
        XFER: begin
          bus.dout     <= bus.din[bus.grant_id];
          bus.frameo_n <= bus.frame_n[bus.grant_id];
          bus.valido_n <= bus.valid_n[bus.grant_id];
          if (!bus.frame_n[bus.grant_id]) started <= 1'b1;
          if (fin || to_hit) begin
            state        <= RELEASE;
            last_ptr     <= bus.grant_id;
            bus.timeout  <= to_hit;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.busy_n   <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.dout     <= 1'b0;
          bus.frameo_n <= 1'b1;
          bus.valido_n <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_router_oport_arb.sv
// tb_router_oport_arb: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_router_oport_arb;
  localparam int TMO = 4;
`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  router_oport_arb_if bus();
  router_oport_arb #(.TIMEOUT_CYCLES(TMO)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // behavioural model: who owns the port, whether a frame began, release pending, rotating pointer
  int          m_owner = -1, m_last = 15, m_idle = 0;
  bit          m_rel = 1'b0, m_started = 1'b0;
  logic [15:0] e_grant = '0;
  logic [3:0]  e_id = '0;
  logic        e_busy = 1'b1, e_dout = 1'b0, e_fo = 1'b1, e_vo = 1'b1, e_to = 1'b0;
  task automatic m_reset;
    m_owner = -1; m_last = 15; m_idle = 0; m_rel = 1'b0; m_started = 1'b0;
    e_grant = '0; e_id = '0; e_busy = 1'b1; e_dout = 1'b0; e_fo = 1'b1; e_vo = 1'b1; e_to = 1'b0;
  endtask
  task automatic m_step;
    int o;
    bit fin, tmo;
    e_to = 1'b0;
    if (m_owner >= 0) begin
      o = m_owner;
      e_dout = bus.din[o]; e_fo = bus.frame_n[o]; e_vo = bus.valid_n[o];
      fin = m_started && bus.frame_n[o];
      m_idle = bus.valid_n[o] ? m_idle + 1 : 0;
      tmo = TO_EN && m_idle >= TMO;
      if (!bus.frame_n[o]) m_started = 1'b1;
      if (fin || tmo) begin
        m_last = o; m_owner = -1; m_rel = 1'b1; e_to = tmo;
        e_grant = '0; e_id = '0; e_busy = 1'b1;
      end
    end else if (m_rel) begin
      m_rel = 1'b0; e_dout = 1'b0; e_fo = 1'b1; e_vo = 1'b1;
    end else if (bus.req != 0) begin
      for (int k = 1; k <= 16; k++)
        if (bus.req[(m_last + k) % 16]) begin
          m_owner = (m_last + k) % 16;
          break;
        end
      m_started = 1'b0; m_idle = 0;
      e_grant = 16'(1) << m_owner; e_id = 4'(m_owner); e_busy = 1'b0;
    end
  endtask
  always @(posedge clock or negedge reset_n)
    if (!reset_n) m_reset();
    else m_step();
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask
  // per-cycle comparison against the model, away from the active edge
  always @(negedge clock)
    if (chk_en) begin
      chk("grant", bus.grant, e_grant);
      chk("grant_id", 16'(bus.grant_id), 16'(e_id));
      chk("busy_n", 16'(bus.busy_n), 16'(e_busy));
      chk("dout", 16'(bus.dout), 16'(e_dout));
      chk("frameo_n", 16'(bus.frameo_n), 16'(e_fo));
      chk("valido_n", 16'(bus.valido_n), 16'(e_vo));
      chk("timeout", 16'(bus.timeout), 16'(e_to));
      chk("grant_onehot0", 16'($onehot0(bus.grant)), 16'd1);
    end
  task automatic idle_inputs;
    bus.req = '0; bus.din = '0; bus.frame_n = '1; bus.valid_n = '1;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic wait_grant(input string nm, input logic [15:0] exp);
    int i;
    i = 0;
    while (bus.grant == 0 && i < 40) begin
      @(negedge clock);
      i++;
    end
    chk(nm, bus.grant, exp);
  endtask
  task automatic send_pkt(input int p, input int n);
    for (int b = 0; b < n; b++) begin
      bus.din[p] = 1'($urandom); bus.frame_n[p] = (b == n - 1); bus.valid_n[p] = 1'b0;
      @(negedge clock);
    end
    bus.din[p] = 1'b0; bus.frame_n[p] = 1'b1; bus.valid_n[p] = 1'b1;
  endtask
  task automatic pulse_reset;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  task automatic rnd(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (bus.grant[i]) bus.req[i] = 1'b0;
        else if ($urandom_range(7) == 0) bus.req[i] = 1'b1;
        bus.frame_n[i] = ($urandom_range(4) == 0);
        bus.valid_n[i] = ($urandom_range(7) == 0);
      end
      bus.din = 16'($urandom);
      if (c % 1000 == 999) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(negedge clock);
    end
    idle_inputs();
  endtask
  logic [7:0] pat;
  int         exp_ports [3];
  int         gap;
  initial begin
    idle_inputs();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc(1);
    chk("rst_grant", bus.grant, 16'h0);
    chk("rst_busy_n", 16'(bus.busy_n), 16'd1);
    chk("rst_frameo_n", 16'(bus.frameo_n), 16'd1);
    chk("rst_valido_n", 16'(bus.valido_n), 16'd1);
    chk("rst_dout", 16'(bus.dout), 16'd0);
    // single 8-bit frame from port 0
    bus.req = 16'h0001;
    @(negedge clock);
    chk("r29_grant", bus.grant, 16'h0001);
    chk("r29_grant_id", 16'(bus.grant_id), 16'd0);
    chk("r29_busy_n", 16'(bus.busy_n), 16'd0);
    bus.req = '0;
    pat = 8'b1011_0010;
    for (int b = 0; b < 8; b++) begin
      bus.din[0] = pat[b]; bus.frame_n[0] = (b == 7); bus.valid_n[0] = 1'b0;
      @(negedge clock);
      chk("r29_dout", 16'(bus.dout), 16'(pat[b]));
      chk("r29_valido_n", 16'(bus.valido_n), 16'd0);
      if (b < 7) chk("r29_busy_mid", 16'(bus.busy_n), 16'd0);
    end
    chk("r29_busy_end", 16'(bus.busy_n), 16'd1);
    idle_inputs();
    cyc(2);
    // three packets with req held at 0x8081 from a fresh pointer
    pulse_reset();
    exp_ports = '{0, 7, 15};
    bus.req = 16'h8081;
    for (int i = 0; i < 3; i++) begin
      wait_grant("r30_grant", 16'(1) << exp_ports[i]);
      chk("r30_grant_id", 16'(bus.grant_id), 16'(exp_ports[i]));
      if (i == 2) bus.req = '0;
      send_pkt(exp_ports[i], 3);
      if (i < 2) begin
        gap = 0;
        while (bus.grant == 0 && gap < 10) begin
          gap++;
          @(negedge clock);
        end
        chk("r30_gap", 16'(gap), 16'd2);
      end
    end
    cyc(2);
    // no preemption: port 5 requests while port 3 owns the port
    bus.req = 16'h0008;
    wait_grant("r31_grant3", 16'h0008);
    bus.req = '0;
    for (int b = 0; b < 6; b++) begin
      bus.din[3] = 1'($urandom); bus.frame_n[3] = (b == 5); bus.valid_n[3] = 1'b0;
      if (b == 2) bus.req[5] = 1'b1;
      @(negedge clock);
      if (b < 5) chk("r31_hold", bus.grant, 16'h0008);
    end
    bus.frame_n[3] = 1'b1; bus.valid_n[3] = 1'b1;
    wait_grant("r31_grant5", 16'h0020);
    bus.req[5] = 1'b0;
    send_pkt(5, 2);
    cyc(2);
    // asynchronous reset in the middle of a port 2 packet
    bus.req = 16'h0004;
    wait_grant("r32_grant", 16'h0004);
    bus.req = '0;
    for (int b = 0; b < 3; b++) begin
      bus.din[2] = 1'b1; bus.frame_n[2] = 1'b0; bus.valid_n[2] = 1'b0;
      @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("r32_rst_grant", bus.grant, 16'h0);
    chk("r32_rst_busy_n", 16'(bus.busy_n), 16'd1);
    chk("r32_rst_dout", 16'(bus.dout), 16'd0);
    chk("r32_rst_valido_n", 16'(bus.valido_n), 16'd1);
    chk("r32_rst_timeout", 16'(bus.timeout), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_inputs();
    bus.req = 16'h0004;
    wait_grant("r32_regrant", 16'h0004);
    bus.req = '0;
    send_pkt(2, 2);
    cyc(2);
    // port 1 granted and never presents valid data
    bus.req = 16'h0002;
    wait_grant("r33_grant", 16'h0002);
    bus.req = '0;
    bus.frame_n[1] = 1'b0; bus.valid_n[1] = 1'b1;
`ifdef ROUTER_OPORT_ARB_TIMEOUT_EN
    gap = 0;
    while (!bus.timeout && gap < 12) begin
      @(negedge clock);
      gap++;
    end
    chk("r33_timeout", 16'(bus.timeout), 16'd1);
    chk("r33_busy_n", 16'(bus.busy_n), 16'd1);
    @(negedge clock);
    chk("r33_timeout_pulse", 16'(bus.timeout), 16'd0);
`else
    cyc(20);
    chk("r33_held_grant", bus.grant, 16'h0002);
    chk("r33_held_busy_n", 16'(bus.busy_n), 16'd0);
`endif
    bus.frame_n[1] = 1'b1;
    cyc(3);
    idle_inputs();
    cyc(2);
    rnd(3000);
    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/router_oport_arb.md
ROUTER_OPORT_ARB -- requirements
Module: router_oport_arb

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, XFER cycles without valid data (valid_n high) before forced release; legal 2..65535.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  16  bit i high = input port i has a packet for this output port; level, held by requester until granted.
REQ-005 din  input  16  serial data bit from each input port.
REQ-006 frame_n  input  16  active-low frame from each input port.
REQ-007 valid_n  input  16  active-low data-valid from each input port.
REQ-008 grant  output  16  one-hot grant to the selected input port; all-zero when none.
REQ-009 grant_id  output  4  index of the granted port; 0 when none.
REQ-010 busy_n  output  1  active-low; low while this output port is owned.
REQ-011 dout  output  1  forwarded serial data.
REQ-012 frameo_n  output  1  forwarded active-low frame.
REQ-013 valido_n  output  1  forwarded active-low valid.
REQ-014 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-015 States IDLE, XFER, RELEASE; all outputs registered.
REQ-016 IDLE: req==0 -> stay; else pick first set bit searching upward from (last_ptr+1) mod 16, wrapping; next edge -> XFER with grant, grant_id, busy_n=0.
REQ-017 req changes while in XFER or RELEASE are ignored; no preemption.
REQ-018 XFER: each edge dout<=din[g], frameo_n<=frame_n[g], valido_n<=valid_n[g]; forwarding latency exactly one cycle.
REQ-019 Flag started sets on first edge in XFER sampling frame_n[g]==0; bits presented before started are still forwarded.
REQ-020 started==1 and frame_n[g]==1 sampled -> that bit is forwarded (last bit) and next state RELEASE.
REQ-021 RELEASE (exactly one cycle): grant=0, grant_id=0, busy_n=1, dout=0, frameo_n=1, valido_n=1; last_ptr<=g; -> IDLE.
REQ-022 Outside XFER: dout=0, frameo_n=1, valido_n=1.
REQ-023 Minimum gap between two grants: one RELEASE plus one IDLE cycle.
REQ-024 grant one-hot or zero at all times; grant[grant_id]==1 whenever busy_n==0.

Reset
REQ-025 reset_n low asynchronously forces IDLE, grant=0, grant_id=0, busy_n=1, dout=0, frameo_n=1, valido_n=1, timeout=0, started=0, idle counter=0, last_ptr=15 (port 0 highest priority after reset).
REQ-026 Reset mid-packet abandons the packet with no RELEASE cycle; first arbitration after deassertion follows REQ-016.

Configuration
REQ-027 Macro ROUTER_OPORT_ARB_TIMEOUT_EN defined: 16-bit counter in XFER increments on each edge sampling valid_n[g]==1, clears on valid_n[g]==0 and on XFER entry; reaching TIMEOUT_CYCLES -> RELEASE with timeout pulsed in the RELEASE cycle, last_ptr<=g.
REQ-028 Macro undefined: no counter, timeout tied 0, XFER exits only per REQ-020 or reset.

Verification
REQ-029 Reset then req=0x0001, port 0 sends 8-bit frame -> grant=0x0001, grant_id=0 one cycle after req; dout/frameo_n/valido_n equal port 0 inputs delayed 1 cycle; busy_n high again the cycle after last bit.
REQ-030 req=0x8081 held for three packets -> grants in order ports 0, 7, 15, each separated by RELEASE+IDLE.
REQ-031 Grant to port 3, port 5 raises req mid-packet -> grant unchanged until port 3 frame_n rises; port 5 granted next.
REQ-032 reset_n pulsed low mid-packet of port 2 -> all outputs at reset values immediately, no timeout pulse; next req=0x0004 granted normally.
REQ-033 With ROUTER_OPORT_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, port 1 granted, valid_n[1] held high -> timeout=1 single cycle in RELEASE after 4 idle cycles, busy_n=1; without macro port 1 stays granted indefinitely.
